// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT datapath: sizes, state encoding and
// packed-bus helpers used by the serializer (and a future input deserializer).
package fft_pkg;

    localparam int NPOINT = 8;
    localparam int IDX_W  = 3;

    typedef enum logic {IDLE, STREAM} state_t;

    function automatic int word_w(input int n);
        return 2 ** n;
    endfunction

    // Bit offset of bin k inside a packed bus of w-bit components.
    function automatic int comp_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/fft_output_serializer.sv
// Captures a parallel 8-bin complex FFT frame and streams it out one bin per
// beat over valid/ready, with optional arithmetic right-shift scaling.
module fft_output_serializer
    import fft_pkg::*;
#(
    parameter int N     = 3,
    parameter int SHIFT = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NPOINT*word_w(N)-1:0]    in_r,
    input  logic [NPOINT*word_w(N)-1:0]    in_i,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [word_w(N)-1:0]           out_r,
    output logic [word_w(N)-1:0]           out_i,
    output logic [IDX_W-1:0]               out_idx,
    output logic                           out_last
);

    localparam int W = word_w(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPOINT - 1);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [W-1:0]     frame_r_reg [NPOINT];
    logic [W-1:0]     frame_i_reg [NPOINT];
    logic [W-1:0]     bin_r [NPOINT];
    logic [W-1:0]     bin_i [NPOINT];
    logic             accept;
    logic             transfer;
    logic signed [W-1:0] sel_r;
    logic signed [W-1:0] sel_i;

    generate
        for (genvar gi = 0; gi < NPOINT; gi++) begin : g_unpack
            assign bin_r[gi] = in_r[comp_lsb(gi, W) +: W];
            assign bin_i[gi] = in_i[comp_lsb(gi, W) +: W];
        end
    endgenerate

    // A new frame may land on the same edge the last beat leaves, so the
    // stream runs back-to-back without a bubble.
    assign in_ready  = !rst && ((state_reg == IDLE) ||
                                ((idx_reg == LAST_IDX) && out_ready));
    assign out_valid = (state_reg == STREAM);
    assign accept    = in_valid && in_ready;
    assign transfer  = out_valid && out_ready;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        if (accept) begin
            state_next = STREAM;
            idx_next   = '0;
        end else if (transfer) begin
            if (idx_reg == LAST_IDX) begin
                state_next = IDLE;
            end else begin
                idx_next = idx_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            for (int k = 0; k < NPOINT; k++) begin
                frame_r_reg[k] <= '0;
                frame_i_reg[k] <= '0;
            end
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (accept) begin
                for (int k = 0; k < NPOINT; k++) begin
                    frame_r_reg[k] <= bin_r[k];
                    frame_i_reg[k] <= bin_i[k];
                end
            end
        end
    end

    // Outputs come only from the stored frame, never straight from in_r/in_i.
    assign sel_r    = frame_r_reg[idx_reg];
    assign sel_i    = frame_i_reg[idx_reg];
    assign out_r    = sel_r >>> SHIFT;
    assign out_i    = sel_i >>> SHIFT;
    assign out_idx  = idx_reg;
    assign out_last = out_valid && (idx_reg == LAST_IDX);

endmodule

// File: tb/tb_fft_output_serializer.sv
// Scoreboard bench: two serializers (SHIFT=0 and SHIFT=2) share stimulus; a
// negedge monitor checks both against a queue-based model of the beat stream.
module tb_fft_output_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_r, in_i;
    logic        out_ready;
    logic        in_ready0, in_ready2, out_valid0, out_valid2;
    logic [7:0]  out_r0, out_i0, out_r2, out_i2;
    logic [2:0]  out_idx0, out_idx2;
    logic        out_last0, out_last2;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;
    int cyc_cnt = 0;
    logic prev_rst = 1'b1;

    typedef struct {
        int         idx;
        logic [7:0] r0, i0, r2, i2;
    } beat_t;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    fft_output_serializer #(.N(3), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_r(in_r), .in_i(in_i), .out_valid(out_valid0), .out_ready(out_ready),
        .out_r(out_r0), .out_i(out_i0), .out_idx(out_idx0), .out_last(out_last0)
    );

    fft_output_serializer #(.N(3), .SHIFT(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_r(in_r), .in_i(in_i), .out_valid(out_valid2), .out_ready(out_ready),
        .out_r(out_r2), .out_i(out_i2), .out_idx(out_idx2), .out_last(out_last2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scaling by 2**s with rounding toward minus infinity.
    function automatic logic [7:0] scale(input int v, input int s);
        int d;
        d = 1 << s;
        if (v >= 0) return 8'(v / d);
        return 8'(-((-v + d - 1) / d));
    endfunction

    always @(negedge clk) begin
        logic  exp_ready;
        beat_t b;
        exp_ready = !rst && (exp_q.size() == 0 || (exp_q.size() == 1 && out_ready));
        chk("in_ready0", 32'(in_ready0), 32'(exp_ready));
        chk("in_ready2", 32'(in_ready2), 32'(exp_ready));
        chk("out_valid0", 32'(out_valid0), 32'(exp_q.size() != 0));
        chk("out_valid2", 32'(out_valid2), 32'(exp_q.size() != 0));
        if (prev_rst) begin
            chk("rst_out_r", 32'(out_r0), 32'h0);
            chk("rst_out_i", 32'(out_i0), 32'h0);
            chk("rst_out_idx", 32'(out_idx0), 32'h0);
            chk("rst_out_last", 32'(out_last0), 32'h0);
        end
        if (exp_q.size() != 0 && out_valid0) begin
            b = exp_q[0];
            chk("idx0", 32'(out_idx0), 32'(b.idx));
            chk("last0", 32'(out_last0), 32'(b.idx == 7));
            chk("r0", 32'(out_r0), 32'(b.r0));
            chk("i0", 32'(out_i0), 32'(b.i0));
            chk("idx2", 32'(out_idx2), 32'(b.idx));
            chk("last2", 32'(out_last2), 32'(b.idx == 7));
            chk("r2", 32'(out_r2), 32'(b.r2));
            chk("i2", 32'(out_i2), 32'(b.i2));
            if (out_ready) begin
                $display("beat idx=%0d r=%02h i=%02h r_s2=%02h i_s2=%02h", b.idx, out_r0, out_i0, out_r2, out_i2);
                void'(exp_q.pop_front());
            end
        end
        if (rst) begin
            exp_q.delete();
        end else if (in_valid && exp_ready) begin
            for (int k = 0; k < 8; k++) begin
                int vr, vi;
                vr = int'($signed(in_r[k*8 +: 8]));
                vi = int'($signed(in_i[k*8 +: 8]));
                b.idx = k;
                b.r0 = scale(vr, 0);
                b.i0 = scale(vi, 0);
                b.r2 = scale(vr, 2);
                b.i2 = scale(vi, 2);
                exp_q.push_back(b);
            end
        end
        prev_rst = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_cnt++;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = !(cyc_cnt >= 2 && cyc_cnt <= 4);
        endcase
        if (!in_valid) begin
            in_r = {$urandom, $urandom};
            in_i = {$urandom, $urandom};
        end
    endtask

    task automatic send(input logic [63:0] r, input logic [63:0] i);
        logic got;
        got = 1'b0;
        in_valid = 1'b1;
        in_r = r;
        in_i = i;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            got = in_ready0;
            tick();
        end
        in_valid = 1'b0;
        if (got) cyc_cnt = 0;
        $display("frame r=%016h i=%016h accepted=%0d", r, i, got);
        chk("accept_timeout", 32'(got), 32'h1);
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 500 && !done; n++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !out_valid0;
            if (!done) tick();
        end
        chk("idle_timeout", 32'(done), 32'h1);
        tick();
    endtask

    task automatic wait_idx(input int k);
        logic done;
        done = 1'b0;
        for (int n = 0; n < 500 && !done; n++) begin
            @(negedge clk);
            done = out_valid0 && (out_idx0 == 3'(k));
            if (!done) tick();
        end
        chk("idx_timeout", 32'(done), 32'h1);
    endtask

    initial begin
        logic [63:0] f1r, f1i, f2, f4;
        for (int k = 0; k < 8; k++) begin
            f1r[k*8 +: 8] = 8'(k + 1);
            f1i[k*8 +: 8] = 8'(-(k + 1));
            f2[k*8 +: 8]  = 8'h10;
        end
        f4 = {$urandom, $urandom};
        f4[23:0] = 24'hFD7F80;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_r = '0;
        in_i = '0;
        repeat (3) tick();
        rst = 1'b0;

        send(f1r, f1i);
        wait_idle();

        ready_mode = 2;
        send(f1r, f1i);
        wait_idle();
        ready_mode = 0;

        send(f1r, f1i);
        send(f2, f2);
        wait_idle();

        send(f4, f1i);
        wait_idle();

        send(f1r, f1i);
        wait_idx(3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        send(f2, f1r);
        wait_idle();

        send(f1r, f1i);
        wait_idx(2);
        tick();
        in_valid = 1'b1;
        in_r = ~f1r;
        in_i = ~f1i;
        tick();
        in_valid = 1'b0;
        wait_idle();

        for (int f = 0; f < 40; f++) begin
            ready_mode = int'($urandom_range(0, 1));
            send({$urandom, $urandom}, {$urandom, $urandom});
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 12)) tick();
            end
        end
        ready_mode = 0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
